// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-organised data memory: byte/half/word
// accesses, read-modify-write for sub-word stores, one response per request.
module mem_access_unit #(
    parameter int DEPTH = 32,
    parameter int AW    = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_error,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_address,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   mem_result
);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t        state_reg;
    logic [1:0]    size_reg;
    logic [1:0]    off_reg;
    logic          write_reg;
    logic          signed_reg;
    logic [15:0]   wdata_reg;
    logic          req_ready_reg;
    logic          mem_read_reg;
    logic          mem_write_reg;
    logic [AW-1:0] mem_address_reg;
    logic [31:0]   mem_write_data_reg;
    logic          resp_valid_reg;
    logic [31:0]   resp_rdata_reg;
    logic          resp_error_reg;

    logic [AW-1:0] word_index;
    logic          req_error;
    logic [31:0]   lane_data;
    logic [3:0]    lane_en;
    logic [31:0]   merged_word;
    logic [31:0]   shifted_word;
    logic [31:0]   load_word;

    assign word_index = {2'b00, req_addr[AW-1:2]};

    always_comb begin
        req_error = 1'b0;
        case (req_size)
            SZ_HALF: req_error = req_addr[0];
            SZ_WORD: req_error = (req_addr[1:0] != 2'b00);
            SZ_RSVD: req_error = 1'b1;
            default: req_error = 1'b0;
        endcase
        if (word_index >= AW'(DEPTH)) begin
            req_error = 1'b1;
        end
    end

    // Replicate the store data across lanes, then pick per-lane between it and the old word.
    assign lane_data = (size_reg == SZ_BYTE) ? {4{wdata_reg[7:0]}} : {2{wdata_reg[15:0]}};

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_en[gi] = (size_reg == SZ_BYTE) ? (off_reg == 2'(gi))
                                                   : (off_reg[1] == ((gi / 2) == 1));
        assign merged_word[8*gi +: 8] = lane_en[gi] ? lane_data[8*gi +: 8]
                                                    : mem_result[8*gi +: 8];
    end

    assign shifted_word = mem_result >> {off_reg, 3'b000};

    always_comb begin
        case (size_reg)
            SZ_BYTE: load_word = {{24{signed_reg & shifted_word[7]}},  shifted_word[7:0]};
            SZ_HALF: load_word = {{16{signed_reg & shifted_word[15]}}, shifted_word[15:0]};
            default: load_word = mem_result;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg          <= IDLE;
            size_reg           <= 2'b00;
            off_reg            <= 2'b00;
            write_reg          <= 1'b0;
            signed_reg         <= 1'b0;
            wdata_reg          <= 16'h0;
            req_ready_reg      <= 1'b0;
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_address_reg    <= '0;
            mem_write_data_reg <= 32'h0;
            resp_valid_reg     <= 1'b0;
            resp_rdata_reg     <= 32'h0;
            resp_error_reg     <= 1'b0;
        end else begin
            // Strobes and response fields are single-cycle unless a state re-asserts them.
            req_ready_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'h0;
            resp_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_ready_reg && req_valid) begin
                        size_reg   <= req_size;
                        off_reg    <= req_addr[1:0];
                        write_reg  <= req_write;
                        signed_reg <= req_signed;
                        wdata_reg  <= req_wdata[15:0];
                        if (req_error) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_error_reg <= 1'b1;
                        end else if (req_write && req_size == SZ_WORD) begin
                            state_reg          <= WRITE;
                            mem_write_reg      <= 1'b1;
                            mem_address_reg    <= word_index;
                            mem_write_data_reg <= req_wdata;
                        end else begin
                            state_reg       <= READ;
                            mem_read_reg    <= 1'b1;
                            mem_address_reg <= word_index;
                        end
                    end else begin
                        req_ready_reg <= 1'b1;
                    end
                end
                READ: begin
                    state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    if (write_reg) begin
                        state_reg          <= WRITE;
                        mem_write_reg      <= 1'b1;
                        mem_write_data_reg <= merged_word;
                    end else begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= load_word;
                    end
                end
                WRITE: begin
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                end
                RESP: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_reg;
    assign mem_read       = mem_read_reg;
    assign mem_write      = mem_write_reg;
    assign mem_address    = mem_address_reg;
    assign mem_write_data = mem_write_data_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_rdata     = resp_rdata_reg;
    assign resp_error     = resp_error_reg;

endmodule
